// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the syncfifo write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DATA_W_DEF    = 32;
    localparam int MAX_BURST_DEF = 4;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int id_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping upward.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    idx
);

    // Scan from the farthest offset down so the nearest match is written last.
    always_comb begin
        any = |req;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ])
                idx = ID_W'((int'(ptr) + k) % NUM_REQ);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the syncfifo write port between producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    localparam int ID_W     = id_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_we,
    output logic [DATA_W-1:0]         fifo_din,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id
);

    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    arb_state_e        state, state_n;
    logic [ID_W-1:0]   owner, owner_n;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_n;
    logic [BCNT_W-1:0] beat_cnt, beat_cnt_n;

    logic              pick_any;
    logic [ID_W-1:0]   pick_idx;
    logic              xfer;
    logic [ID_W-1:0]   owner_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_ptr   <= rr_ptr_n;
            beat_cnt <= beat_cnt_n;
        end
    end

    assign owner_inc = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_ptr_n    = rr_ptr;
        beat_cnt_n  = beat_cnt;
        xfer        = 1'b0;
        fifo_we     = 1'b0;
        fifo_din    = '0;
        req_ready   = '0;
        grant_valid = 1'b0;
        grant_id    = '0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    owner_n    = pick_idx;
                    beat_cnt_n = '0;
                    state_n    = GRANT;
                end
            end
            GRANT: begin
                grant_valid       = 1'b1;
                grant_id          = owner;
                req_ready[owner]  = !fifo_full;
                xfer              = req_valid[owner] && !fifo_full;
                fifo_we           = xfer;
                if (xfer)
                    fifo_din = req_data[owner*DATA_W +: DATA_W];

                // An idle owner gives up the port even while the FIFO is full.
                if (!req_valid[owner]) begin
                    state_n  = IDLE;
                    rr_ptr_n = owner_inc;
                end else if (xfer) begin
                    if (beat_cnt == BCNT_W'(MAX_BURST - 1)) begin
                        state_n  = IDLE;
                        rr_ptr_n = owner_inc;
                    end else begin
                        beat_cnt_n = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
